// File: rtl/pc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_seq_pkg                                                      |
// | Purpose  : Shared state encoding and default constants for the PC fetch    |
// |            sequencer and its helpers.                                      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pc_seq_pkg;

    localparam int unsigned       DEFAULT_WIDTH    = 32;
    localparam logic [31:0]       DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_REQ    = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/branch_target_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_target_adder                                             |
// | Purpose  : PC-relative branch target, pc_plus1 + sign_imm, modulo 2^WIDTH. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module branch_target_adder
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic [WIDTH-1:0] sign_imm,
    output logic [WIDTH-1:0] pc_branch
);

    // Offset is two's complement, so a plain wrapping add handles negatives.
    assign pc_branch = pc_plus1 + sign_imm;

endmodule : branch_target_adder
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_sequencer                                              |
// | Purpose  : Owns the PC, selects the next PC and runs the instruction       |
// |            memory req/ack handshake ahead of decode.                       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] sign_imm,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic [WIDTH-1:0] pc_branch,
    output logic             halted
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] next_pc;

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus1  = pc_q + WIDTH'(1);

    branch_target_adder #(
        .WIDTH (WIDTH)
    ) u_branch_target_adder (
        .pc_plus1  (pc_plus1),
        .sign_imm  (sign_imm),
        .pc_branch (pc_branch)
    );

    // Jump outranks branch when both are raised in the same cycle.
    always_comb begin
        next_pc = pc_plus1;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_branch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Outputs decode straight from state_q so reset removes imem_req at once.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule : pc_fetch_sequencer
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_sequencer                                           |
// | Purpose  : Directed self-checking bench; expected fetch addresses are      |
// |            queued when an instruction retires and popped at fetch.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_sequencer;

    localparam int unsigned C_WIDTH    = 32;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] sign_imm;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] pc_branch;
    logic        halted;

    logic [31:0] exp_q[$];
    logic [31:0] cur_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    pc_fetch_sequencer #(
        .WIDTH    (C_WIDTH),
        .RESET_PC (C_RESET_PC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .sign_imm     (sign_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .halt         (halt),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .pc_branch    (pc_branch),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_redirects();
        stall        = 1'b0;
        branch_taken = 1'b0;
        sign_imm     = 32'h0;
        jump         = 1'b0;
        jump_target  = 32'h0;
        halt         = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_pc", pc, C_RESET_PC);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("boot_req", {31'b0, imem_req}, 32'd0);
        exp_q.delete();
        exp_q.push_back(C_RESET_PC);
        tick();
    endtask

    // Expects the DUT in REQ; holds ack low for wait_cycles, then acks.
    task automatic fetch(input int wait_cycles);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        imem_ack = (wait_cycles == 0);
        for (int i = 0; i < wait_cycles; i++) begin
            check("req_hold", {31'b0, imem_req}, 32'd1);
            check("addr_hold", imem_addr, exp);
            tick();
        end
        check("req", {31'b0, imem_req}, 32'd1);
        check("addr", imem_addr, exp);
        imem_ack = 1'b1;
        tick();
        check("exec_valid", {31'b0, instr_valid}, 32'd1);
        check("exec_req", {31'b0, imem_req}, 32'd0);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("exec_pc", pc, exp);
        end
        cur_pc = pc;
    endtask

    // Expects the DUT in EXEC; optional stall, then retires with the given redirect.
    task automatic exec_instr(input int stall_cycles, input logic br, input logic [31:0] imm,
                              input logic jmp, input logic [31:0] tgt, input logic hlt);
        logic [31:0] nxt;
        branch_taken = br;
        sign_imm     = imm;
        jump         = jmp;
        jump_target  = tgt;
        halt         = hlt;
        stall        = (stall_cycles > 0);
        #1;
        check("pc_plus1", pc_plus1, cur_pc + 32'd1);
        check("pc_branch", pc_branch, cur_pc + 32'd1 + imm);
        for (int i = 0; i < stall_cycles; i++) begin
            tick();
            check("stall_pc", pc, cur_pc);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        nxt = jmp ? tgt : (br ? (cur_pc + 32'd1 + imm) : (cur_pc + 32'd1));
        exp_q.push_back(nxt);
        tick();
        clear_redirects();
        if (hlt) begin
            check("halt_flag", {31'b0, halted}, 32'd1);
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, instr_valid}, 32'd0);
            check("halt_pc", pc, exp_q.pop_front());
        end else begin
            check("retire_req", {31'b0, imem_req}, 32'd1);
            check("retire_valid", {31'b0, instr_valid}, 32'd0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        imem_ack = 1'b1;
        cur_pc   = 32'h0;
        clear_redirects();
        tick();

        // Sequential fetch with ack tied high
        do_reset();
        fetch(0);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        fetch(0);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        fetch(0);
        check("t1_pc12", pc, 32'h12);
        exec_instr(0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);

        // Negative branch from 0x20
        fetch(0);
        check("t2_pc20", pc, 32'h20);
        exec_instr(0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        fetch(0);
        check("t2_pc1d", pc, 32'h1D);

        // Jump beats branch
        exec_instr(0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
        fetch(1);
        exec_instr(0, 1'b1, 32'h8, 1'b1, 32'h400, 1'b0);
        fetch(0);
        check("t3_pc400", pc, 32'h400);

        // Delayed ack and stalled branch
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        fetch(3);
        exec_instr(2, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0);
        fetch(0);
        check("t4_pc407", pc, 32'h407);

        // Wrap at all-ones, then halt
        exec_instr(0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        fetch(2);
        check("t5_plus1_wrap", pc_plus1, 32'h0);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        fetch(0);
        check("t5_pc0", pc, 32'h0);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        imem_ack = 1'b1;
        jump     = 1'b1;
        jump_target = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halted_stay", {31'b0, halted}, 32'd1);
            check("halted_req", {31'b0, imem_req}, 32'd0);
            check("halted_pc", pc, 32'h1);
        end
        clear_redirects();

        // Reset out of HALTED, then reset mid-REQ
        do_reset();
        fetch(0);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        imem_ack = 1'b0;
        #3;
        check("t6_in_req", {31'b0, imem_req}, 32'd1);
        do_reset();
        fetch(1);
        check("t6_restart_pc", pc, C_RESET_PC);
        exec_instr(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        fetch(0);
        check("t6_pc11", pc, 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_sequencer
`default_nettype wire
